// File: rtl/spi_master_fifo_ctrl.sv
// Queues TX words and runs one spi_master transfer per word, capturing replies into an RX FIFO; Start fires 3 cycles after an idle push.
// Backpressure: InReady drops when TX is full; transfers stall in IDLE until an RX slot is free, so RX never overruns.

module spi_master_fifo_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign level    = level_q;

endmodule

module spi_master_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int TX_DEPTH   = 4,
  parameter int RX_DEPTH   = 4,
  localparam int TLW = $clog2(TX_DEPTH) + 1,
  localparam int RLW = $clog2(RX_DEPTH) + 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [1:0]            CfgMode,
  input  logic [DATA_WIDTH-1:0] InData,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [TLW-1:0]        TxLevel,
  output logic [RLW-1:0]        RxLevel,
  output logic                  Busy,
  output logic                  MStart,
  output logic [DATA_WIDTH-1:0] MTxData,
  output logic [1:0]            MMode,
  input  logic                  MDone,
  input  logic [DATA_WIDTH-1:0] MRxData
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_STORE} state_t;

  localparam logic [TLW-1:0] TX_FULL_LVL = TLW'(TX_DEPTH);
  localparam logic [RLW-1:0] RX_FULL_LVL = RLW'(RX_DEPTH);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mtx_data_q, mtx_data_d;
  logic [1:0]            mmode_q, mmode_d;
  logic                  mdone_q, mdone_d;

  logic                  tx_push, tx_pop, rx_push, rx_pop;
  logic [DATA_WIDTH-1:0] tx_head;
  logic [RLW-1:0]        rx_level_nxt;

  assign tx_push = InValid && InReady;
  assign rx_pop  = OutValid && OutReady;

  spi_master_fifo_ctrl_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk      (Clk),
    .rst      (Reset),
    .push     (tx_push),
    .push_dat (InData),
    .pop      (tx_pop),
    .head_dat (tx_head),
    .level    (TxLevel)
  );

  spi_master_fifo_ctrl_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk      (Clk),
    .rst      (Reset),
    .push     (rx_push),
    .push_dat (MRxData),
    .pop      (rx_pop),
    .head_dat (OutData),
    .level    (RxLevel)
  );

  // Only consulted in IDLE, where nothing is in flight and RX is never pushed,
  // so the reserved slot is zero and the next level is just the current level minus a pop.
  assign rx_level_nxt = RxLevel - RLW'(rx_pop);

  always_comb begin
    state_d    = state_q;
    mtx_data_d = mtx_data_q;
    mmode_d    = mmode_q;
    mdone_d    = MDone;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((TxLevel != '0) && (rx_level_nxt < RX_FULL_LVL)) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_pop     = 1'b1;
        mtx_data_d = tx_head;
        mmode_d    = CfgMode;
        state_d    = S_START;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // A Done level left high by the previous transfer must not complete this one.
        if (MDone && !mdone_q) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        rx_push = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      mtx_data_q <= '0;
      mmode_q    <= '0;
      mdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtx_data_q <= mtx_data_d;
      mmode_q    <= mmode_d;
      mdone_q    <= mdone_d;
    end
  end

  assign InReady  = (TxLevel != TX_FULL_LVL);
  assign OutValid = (RxLevel != '0);
  assign Busy     = (state_q != S_IDLE);
  assign MStart   = (state_q == S_START);
  assign MTxData  = mtx_data_q;
  assign MMode    = mmode_q;

endmodule

// File: tb/tb_spi_master_fifo_ctrl.sv
// Bench for spi_master_fifo_ctrl: an spi_master stand-in answers each MStart, scoreboard queues hold expected TX/RX/mode order.
`timescale 1ns/1ps

module tb_spi_master_fifo_ctrl;

  logic       Clk, Reset;
  logic [1:0] CfgMode;
  logic [7:0] InData, OutData, MTxData, MRxData;
  logic       InValid, InReady, OutValid, OutReady, Busy, MStart, MDone;
  logic [2:0] TxLevel, RxLevel;
  logic [1:0] MMode;

  spi_master_fifo_ctrl #(.DATA_WIDTH(8), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .CfgMode(CfgMode), .InData(InData), .InValid(InValid),
    .InReady(InReady), .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
    .TxLevel(TxLevel), .RxLevel(RxLevel), .Busy(Busy), .MStart(MStart), .MTxData(MTxData),
    .MMode(MMode), .MDone(MDone), .MRxData(MRxData)
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  logic [1:0] exp_mode[$];
  logic [7:0] slave_q[$];
  logic [7:0] mtx_obs[$];
  logic [1:0] mode_obs[$];
  int         slave_dly = 4;
  bit         hold_done = 1'b0;
  int         start_cnt = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200us");
    $fatal(1);
  end

  // spi_master stand-in: acts mid-cycle, completes slave_dly+1 cycles after MStart.
  initial begin
    logic [7:0] cur_rx;
    int cnt;
    cnt = -1;
    cur_rx = '0;
    MDone = 1'b0;
    MRxData = '0;
    forever begin
      @(posedge Clk); #3;
      if (Reset) begin
        cnt = -1;
        MDone = 1'b0;
      end else begin
        if (!hold_done || cnt == 1) MDone = 1'b0;
        if (cnt == 0) begin
          MRxData = cur_rx;
          MDone = 1'b1;
        end
        if (cnt >= 0) cnt--;
        if (MStart) begin
          start_cnt++;
          mtx_obs.push_back(MTxData);
          mode_obs.push_back(MMode);
          if (slave_q.size() > 0) cur_rx = slave_q.pop_front();
          else cur_rx = 8'h00;
          cnt = slave_dly;
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic push_word(input logic [7:0] d, output bit ok);
    int n = 0;
    InData = d;
    InValid = 1'b1;
    while (!InReady && n < 200) begin tick(); n++; end
    ok = InReady;
    tick();
    InValid = 1'b0;
  endtask

  task automatic pop_word(output logic [7:0] d, output bit ok);
    int n = 0;
    while (!OutValid && n < 200) begin tick(); n++; end
    ok = OutValid;
    d = OutData;
    OutReady = ok;
    tick();
    OutReady = 1'b0;
  endtask

  task automatic queue_word(input logic [7:0] tx, input logic [7:0] rx, input logic [1:0] mode);
    exp_tx.push_back(tx);
    exp_rx.push_back(rx);
    exp_mode.push_back(mode);
    slave_q.push_back(rx);
  endtask

  task automatic test_reset();
    InValid = 1'b0; InData = '0; OutReady = 1'b0; CfgMode = 2'd0;
    #2 Reset = 1'b1;
    repeat (3) tick();
    tests_run++; if (InReady !== 1'b1) begin tests_failed++; $display("FAIL reset_inready: got %b want 1", InReady); end
    tests_run++; if (OutValid !== 1'b0) begin tests_failed++; $display("FAIL reset_outvalid: got %b want 0", OutValid); end
    tests_run++; if (TxLevel !== 3'd0) begin tests_failed++; $display("FAIL reset_txlevel: got %0d want 0", TxLevel); end
    tests_run++; if (RxLevel !== 3'd0) begin tests_failed++; $display("FAIL reset_rxlevel: got %0d want 0", RxLevel); end
    tests_run++; if (Busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", Busy); end
    tests_run++; if (MStart !== 1'b0) begin tests_failed++; $display("FAIL reset_mstart: got %b want 0", MStart); end
    tests_run++; if (MTxData !== 8'h00) begin tests_failed++; $display("FAIL reset_mtxdata: got %h want 00", MTxData); end
    tests_run++; if (MMode !== 2'd0) begin tests_failed++; $display("FAIL reset_mmode: got %0d want 0", MMode); end
    @(posedge Clk); #4 Reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n, s0;
    logic [7:0] e;
    s0 = start_cnt;
    slave_dly = 4;
    queue_word(8'hA5, 8'hD6, 2'd0);
    CfgMode = 2'd0;
    InData = 8'hA5; InValid = 1'b1;
    tick();
    InValid = 1'b0;
    n = 1;
    while (!MStart && n < 20) begin tick(); n++; end
    tests_run++; if (n !== 3) begin tests_failed++; $display("FAIL single_start_latency: got %0d cycles want 3", n); end
    tests_run++; if (MTxData !== 8'hA5) begin tests_failed++; $display("FAIL single_mtxdata: got %h want a5", MTxData); end
    tests_run++; if (MMode !== 2'd0) begin tests_failed++; $display("FAIL single_mmode: got %0d want 0", MMode); end
    tick();
    tests_run++; if (MStart !== 1'b0) begin tests_failed++; $display("FAIL single_pulse_width: MStart got %b want 0", MStart); end
    n = 0;
    while (!MDone && n < 50) begin tick(); n++; end
    // MDone is driven mid-cycle, so the first sample showing it is one cycle after the rise.
    n = 1;
    while (!OutValid && n < 20) begin tick(); n++; end
    tests_run++; if (n !== 2) begin tests_failed++; $display("FAIL single_outvalid_latency: got %0d cycles want 2", n); end
    e = exp_rx.pop_front();
    tests_run++; if (OutData !== e) begin tests_failed++; $display("FAIL single_outdata: got %h want %h", OutData, e); end
    tests_run++; if (RxLevel !== 3'd1) begin tests_failed++; $display("FAIL single_rxlevel: got %0d want 1", RxLevel); end
    repeat (3) tick();
    tests_run++; if (start_cnt - s0 !== 1) begin tests_failed++; $display("FAIL single_start_count: got %0d want 1", start_cnt - s0); end
    e = exp_tx.pop_front();
    void'(exp_mode.pop_front());
    void'(mode_obs.pop_front());
    tests_run++; if (mtx_obs.pop_front() !== e) begin tests_failed++; $display("FAIL single_obs_tx: want %h", e); end
    OutReady = 1'b1; tick(); OutReady = 1'b0;
    tests_run++; if (RxLevel !== 3'd0 || OutValid !== 1'b0) begin tests_failed++; $display("FAIL single_pop: RxLevel %0d OutValid %b want 0 0", RxLevel, OutValid); end
  endtask

  task automatic test_back_to_back();
    int s0;
    bit ok;
    logic [7:0] d, e;
    s0 = start_cnt;
    slave_dly = 12;
    for (int i = 0; i < 5; i++) queue_word(8'h10 + 8'(i), 8'hC0 + 8'(i), 2'd0);
    for (int i = 0; i < 5; i++) begin
      push_word(8'h10 + 8'(i), ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_push%0d: InReady timeout", i); end
    end
    tests_run++; if (InReady !== 1'b0) begin tests_failed++; $display("FAIL b2b_full_inready: got %b want 0", InReady); end
    tests_run++; if (TxLevel !== 3'd4) begin tests_failed++; $display("FAIL b2b_full_txlevel: got %0d want 4", TxLevel); end
    for (int i = 0; i < 5; i++) begin
      pop_word(d, ok);
      e = exp_rx.pop_front();
      tests_run++; if (!ok || d !== e) begin tests_failed++; $display("FAIL b2b_rx%0d: got %h (valid %b) want %h", i, d, ok, e); end
    end
    tests_run++; if (start_cnt - s0 !== 5) begin tests_failed++; $display("FAIL b2b_start_count: got %0d want 5", start_cnt - s0); end
    for (int i = 0; i < 5; i++) begin
      e = exp_tx.pop_front();
      d = (mtx_obs.size() > 0) ? mtx_obs.pop_front() : 8'hxx;
      tests_run++; if (d !== e) begin tests_failed++; $display("FAIL b2b_tx%0d: got %h want %h", i, d, e); end
    end
    exp_mode.delete(); mode_obs.delete();
  endtask

  task automatic test_rx_stall();
    int s0;
    bit ok;
    logic [7:0] d, e;
    s0 = start_cnt;
    slave_dly = 4;
    OutReady = 1'b0;
    for (int i = 0; i < 6; i++) queue_word(8'h30 + 8'(i), 8'h60 + 8'(i), 2'd0);
    for (int i = 0; i < 6; i++) begin
      push_word(8'h30 + 8'(i), ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL stall_push%0d: InReady timeout", i); end
    end
    repeat (80) tick();
    tests_run++; if (start_cnt - s0 !== 4) begin tests_failed++; $display("FAIL stall_start_count: got %0d want 4", start_cnt - s0); end
    tests_run++; if (Busy !== 1'b0) begin tests_failed++; $display("FAIL stall_busy: got %b want 0", Busy); end
    tests_run++; if (TxLevel !== 3'd2) begin tests_failed++; $display("FAIL stall_txlevel: got %0d want 2", TxLevel); end
    tests_run++; if (RxLevel !== 3'd4) begin tests_failed++; $display("FAIL stall_rxlevel: got %0d want 4", RxLevel); end
    for (int i = 0; i < 6; i++) begin
      pop_word(d, ok);
      e = exp_rx.pop_front();
      tests_run++; if (!ok || d !== e) begin tests_failed++; $display("FAIL stall_rx%0d: got %h (valid %b) want %h", i, d, ok, e); end
    end
    tests_run++; if (start_cnt - s0 !== 6 || TxLevel !== 3'd0) begin tests_failed++; $display("FAIL stall_resume: starts %0d TxLevel %0d want 6 0", start_cnt - s0, TxLevel); end
    for (int i = 0; i < 6; i++) begin
      e = exp_tx.pop_front();
      d = (mtx_obs.size() > 0) ? mtx_obs.pop_front() : 8'hxx;
      tests_run++; if (d !== e) begin tests_failed++; $display("FAIL stall_tx%0d: got %h want %h", i, d, e); end
    end
    exp_mode.delete(); mode_obs.delete();
  endtask

  task automatic test_mode();
    int n;
    bit ok;
    logic [7:0] d, e;
    logic [1:0] m, em;
    slave_dly = 10;
    CfgMode = 2'd0;
    queue_word(8'h5A, 8'hA1, 2'd0);
    push_word(8'h5A, ok);
    n = 0;
    while (!MStart && n < 20) begin tick(); n++; end
    tick(); tick();
    CfgMode = 2'd3;
    repeat (4) tick();
    tests_run++; if (MMode !== 2'd0 || Busy !== 1'b1) begin tests_failed++; $display("FAIL mode_hold: MMode %0d Busy %b want 0 1", MMode, Busy); end
    queue_word(8'h7E, 8'hB2, 2'd3);
    push_word(8'h7E, ok);
    for (int i = 0; i < 2; i++) begin
      pop_word(d, ok);
      e = exp_rx.pop_front();
      tests_run++; if (!ok || d !== e) begin tests_failed++; $display("FAIL mode_rx%0d: got %h want %h", i, d, e); end
    end
    for (int i = 0; i < 2; i++) begin
      em = exp_mode.pop_front();
      m = (mode_obs.size() > 0) ? mode_obs.pop_front() : 2'bxx;
      tests_run++; if (m !== em) begin tests_failed++; $display("FAIL mode_xfer%0d: MMode got %0d want %0d", i, m, em); end
    end
    tests_run++; if (MMode !== 2'd3) begin tests_failed++; $display("FAIL mode_final: got %0d want 3", MMode); end
    exp_tx.delete(); mtx_obs.delete();
    CfgMode = 2'd0;
  endtask

  task automatic test_reset_mid();
    int n, s1;
    bit ok;
    logic [7:0] d, e;
    slave_dly = 10;
    push_word(8'h99, ok);
    push_word(8'h98, ok);
    n = 0;
    while (!MStart && n < 20) begin tick(); n++; end
    tick(); tick();
    tests_run++; if (Busy !== 1'b1 || TxLevel !== 3'd1) begin tests_failed++; $display("FAIL rstmid_pre: Busy %b TxLevel %0d want 1 1", Busy, TxLevel); end
    #3 Reset = 1'b1;
    #1;
    tests_run++; if (MStart !== 1'b0 || Busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ctrl: MStart %b Busy %b want 0 0", MStart, Busy); end
    tests_run++; if (TxLevel !== 3'd0 || RxLevel !== 3'd0) begin tests_failed++; $display("FAIL rstmid_levels: Tx %0d Rx %0d want 0 0", TxLevel, RxLevel); end
    tests_run++; if (OutValid !== 1'b0 || InReady !== 1'b1) begin tests_failed++; $display("FAIL rstmid_flags: OutValid %b InReady %b want 0 1", OutValid, InReady); end
    @(posedge Clk); @(posedge Clk); #4 Reset = 1'b0;
    tick();
    mtx_obs.delete(); mode_obs.delete();
    s1 = start_cnt;
    repeat (6) tick();
    tests_run++; if (start_cnt !== s1 || Busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_stray: starts %0d Busy %b want 0 0", start_cnt - s1, Busy); end
    slave_dly = 4;
    queue_word(8'hC3, 8'h3C, 2'd0);
    push_word(8'hC3, ok);
    pop_word(d, ok);
    e = exp_rx.pop_front();
    tests_run++; if (!ok || d !== e) begin tests_failed++; $display("FAIL rstmid_fresh_rx: got %h want %h", d, e); end
    e = exp_tx.pop_front();
    d = (mtx_obs.size() > 0) ? mtx_obs.pop_front() : 8'hxx;
    tests_run++; if (d !== e) begin tests_failed++; $display("FAIL rstmid_fresh_tx: got %h want %h", d, e); end
    exp_mode.delete(); mode_obs.delete();
  endtask

  task automatic test_mdone_hold();
    int n, s0;
    bit ok;
    logic [7:0] d, e;
    s0 = start_cnt;
    hold_done = 1'b1;
    slave_dly = 4;
    OutReady = 1'b0;
    for (int i = 0; i < 5; i++) queue_word(8'h80 + 8'(i), 8'hE0 + 8'(i), 2'd0);
    for (int i = 0; i < 5; i++) push_word(8'h80 + 8'(i), ok);
    repeat (70) tick();
    tests_run++; if (RxLevel !== 3'd4 || TxLevel !== 3'd1) begin tests_failed++; $display("FAIL hold_full_levels: Rx %0d Tx %0d want 4 1", RxLevel, TxLevel); end
    tests_run++; if (Busy !== 1'b0 || start_cnt - s0 !== 4) begin tests_failed++; $display("FAIL hold_stall: Busy %b starts %0d want 0 4", Busy, start_cnt - s0); end
    // Pop at RX full: IDLE must see the freed slot in the same cycle.
    d = OutData;
    OutReady = 1'b1; tick(); OutReady = 1'b0;
    e = exp_rx.pop_front();
    tests_run++; if (d !== e) begin tests_failed++; $display("FAIL hold_pop0: got %h want %h", d, e); end
    tests_run++; if (RxLevel !== 3'd3 || Busy !== 1'b1) begin tests_failed++; $display("FAIL hold_pop_decision: Rx %0d Busy %b want 3 1", RxLevel, Busy); end
    n = 0;
    while (MDone && n < 50) begin tick(); n++; end
    while (!MDone && n < 50) begin tick(); n++; end
    // Now in STORE: pop in the same cycle as the RX push.
    d = OutData;
    OutReady = 1'b1; tick(); OutReady = 1'b0;
    e = exp_rx.pop_front();
    tests_run++; if (d !== e) begin tests_failed++; $display("FAIL hold_pop1: got %h want %h", d, e); end
    tests_run++; if (RxLevel !== 3'd3 || TxLevel !== 3'd0) begin tests_failed++; $display("FAIL hold_pushpop_level: Rx %0d Tx %0d want 3 0", RxLevel, TxLevel); end
    hold_done = 1'b0;
    for (int i = 2; i < 5; i++) begin
      pop_word(d, ok);
      e = exp_rx.pop_front();
      tests_run++; if (!ok || d !== e) begin tests_failed++; $display("FAIL hold_rx%0d: got %h want %h", i, d, e); end
    end
    tests_run++; if (start_cnt - s0 !== 5 || RxLevel !== 3'd0) begin tests_failed++; $display("FAIL hold_end: starts %0d Rx %0d want 5 0", start_cnt - s0, RxLevel); end
    for (int i = 0; i < 5; i++) begin
      e = exp_tx.pop_front();
      d = (mtx_obs.size() > 0) ? mtx_obs.pop_front() : 8'hxx;
      tests_run++; if (d !== e) begin tests_failed++; $display("FAIL hold_tx%0d: got %h want %h", i, d, e); end
    end
  endtask

  initial begin
    Reset = 1'b0;
    InValid = 1'b0;
    InData = '0;
    OutReady = 1'b0;
    CfgMode = 2'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_rx_stall();
    test_mode();
    test_reset_mid();
    test_mdone_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
